uart_result_tx: RTL and testbench
=================================

# uart_result_tx

- Serializes one 32-bit frequency-measurement result into a fixed 6-byte frame and transmits it as UART 8N1 on the board TX pin.
- Sits between the counter/measurement core and the top-level `uart_tx_ext` pad.
- Acts as the transmitting end of the host UART link that the top level exposes.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 2.
- `clk_i` input 1: single system clock; all logic is on its rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `data_i` input 32: measurement word to send. Captured at the handshake.
- `data_valid_i` input 1: source has a word on `data_i`.
- `data_ready_o` output 1: block can accept a word. High only when the frame FSM is IDLE and `rst_i` is low.
- `uart_tx_o` output 1: serial line. Idle level is high.
- `busy_o` output 1: high from the cycle after acceptance until the frame completes.
- `frame_done_o` output 1: one-cycle pulse when the last stop bit has finished.

## Operation
- Handshake: a word is accepted on a rising edge where `data_valid_i & data_ready_o`. The word is latched into a 32-bit register, and later changes on `data_i` are ignored.
- Frame content, in order: 0xA5, D[31:24], D[23:16], D[15:8], D[7:0], CHK.
  - CHK = D[31:24] ^ D[23:16] ^ D[15:8] ^ D[7:0].
  - CHK is computed from the latched word.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly `CLKS_PER_BIT` cycles.
- Frame FSM states:
  - IDLE → SEND on handshake.
  - SEND → SEND while byte index < 5 and the byte engine signals done (index increments).
  - SEND → DONE when byte 5 is done.
  - DONE → IDLE unconditionally, after one cycle.
- Byte engine FSM states:
  - IDLE → START on a load strobe.
  - START → DATA after one bit period.
  - DATA → STOP after 8 bit periods.
  - STOP → IDLE after one bit period, asserting done for 1 cycle.
- Bytes are sent back-to-back: the start bit of byte k+1 begins on the cycle right after the stop bit of byte k ends, with no idle gap.
- Bit-period counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
- `data_valid_i` asserted while busy has no effect, because `data_ready_o` = 0.

## Timing
- Reset values:
  - `uart_tx_o` = 1.
  - `data_ready_o` = 0 while `rst_i` is high, and 1 on the first cycle after `rst_i` falls.
  - `busy_o` = 0, `frame_done_o` = 0.
  - Both FSMs go to IDLE, and the byte index and bit counters go to 0.
- Latency: for a handshake at edge N, `uart_tx_o` goes low (first start bit) in the cycle following edge N+1, i.e. one register stage.
- Frame length: 60 × `CLKS_PER_BIT` cycles from the first start-bit cycle to the end of the last stop bit.
- `frame_done_o` is high for exactly one cycle, the DONE state, immediately after the final stop bit.
- `busy_o` falls and `data_ready_o` rises on the cycle after DONE.
- Minimum spacing between consecutive frames' first start bits is 60 × `CLKS_PER_BIT` + 3 cycles.
- Reset mid-frame: at the next edge `uart_tx_o` returns to 1 and all state is cleared. No `frame_done_o` is emitted, and the partial frame is not resumed.
- Reset asserted in the same cycle as a handshake: reset wins and the word is dropped.

## Structure
- Put the following in the shared `freq_counter_pkg`:
  - `SYNC_BYTE` = 8'hA5.
  - `FRAME_BYTES` = 6.
  - Frame FSM state encodings.
  - The byte-engine state typedef.
- One sub-module, `uart_tx_byte`:
  - Ports: clk, reset, 8-bit load data, load strobe, `tx` bit, done pulse, busy.
  - Parameter: `CLKS_PER_BIT`.
  - Reusable by any other UART transmit path in the design.
- The top file holds the handshake, data latch, checksum, byte mux (indexed by a 3-bit byte counter) and the frame FSM.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.
- Basic frame: send `data_i` = 0x12345678 → line decodes A5 12 34 56 78 08.
  - First start bit appears 1 cycle after the handshake.
  - `frame_done_o` pulses exactly once, 240 cycles after the first start bit.
- Data stability: send 0xFFFFFFFF, then drive `data_i` = 0 during the frame → line decodes A5 FF FF FF FF 00, unaffected by the later input.
- Hold-off: hold `data_valid_i` high for 500 cycles with 0x00000001 then 0x80000000 → two consecutive frames are accepted.
  - `data_ready_o` stays 0 during each frame.
  - Frames decode as A5 00 00 00 01 01 and A5 80 00 00 00 80.
  - Gap between frames is 3 cycles.
- Reset mid-frame: assert `rst_i` for 1 cycle during byte 3 → `uart_tx_o` = 1 next cycle and no `frame_done_o`.
  - `data_ready_o` = 1 on the cycle after reset is released.
  - A new 0xA5A5A5A5 frame then decodes as A5 A5 A5 A5 A5 00.
- Line idle and bit width: with no traffic after reset → `uart_tx_o` stays constantly 1.
  - During a frame, every start, data and stop bit lasts exactly 4 cycles (checked by a bench-side monitor).

Source files
------------

// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the frequency-counter result path:
// frame layout, frame/byte FSM encodings and the frame checksum.
package freq_counter_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 6;

  typedef enum logic [1:0] {
    FR_IDLE = 2'd0,
    FR_SEND = 2'd1,
    FR_DONE = 2'd2
  } frame_state_t;

  typedef enum logic [1:0] {
    BT_IDLE  = 2'd0,
    BT_START = 2'd1,
    BT_DATA  = 2'd2,
    BT_STOP  = 2'd3
  } byte_state_t;

  function automatic logic [7:0] frame_chk(input logic [31:0] word);
    return word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter. A load seen during the final stop-bit cycle
// starts the next byte on the following cycle, so bytes can run back-to-back.
module uart_tx_byte
  import freq_counter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       load_i,
  output logic       tx_o,
  output logic       done_o,
  output logic       busy_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  byte_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != BT_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      BT_IDLE: begin
        cnt_d = '0;
        if (load_i) begin
          state_d = BT_START;
          shift_d = data_i;
          tx_d    = 1'b0;
        end
      end
      BT_START: begin
        if (bit_end) begin
          state_d = BT_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      BT_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = BT_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      BT_STOP: begin
        if (bit_end) begin
          if (load_i) begin
            state_d = BT_START;
            shift_d = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = BT_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = BT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BT_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o   = tx_q;
  assign done_o = (state_q == BT_STOP) && bit_end;
  assign busy_o = (state_q != BT_IDLE);

endmodule

// File: rtl/uart_result_tx.sv
// Sends one latched 32-bit measurement as a 6-byte UART frame:
// sync byte, four data bytes MSB first, XOR checksum.
module uart_result_tx
  import freq_counter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  frame_state_t state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [31:0]  word_q, word_d;
  logic         load_q, load_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         chain_load;
  logic         accept;
  logic [7:0]   byte_data;
  logic         byte_load, byte_tx, byte_done, byte_busy;

  assign data_ready_o = (state_q == FR_IDLE) && !rst_i;
  assign accept       = data_valid_i && data_ready_o;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    load_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    chain_load = 1'b0;
    case (state_q)
      FR_IDLE: begin
        if (accept) begin
          state_d = FR_SEND;
          word_d  = data_i;
          idx_d   = 3'd0;
          load_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      FR_SEND: begin
        if (byte_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = FR_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d      = idx_q + 3'd1;
            chain_load = 1'b1;
          end
        end
      end
      FR_DONE: begin
        state_d = FR_IDLE;
        idx_d   = 3'd0;
        busy_d  = 1'b0;
      end
      default: state_d = FR_IDLE;
    endcase
  end

  // Mux follows the next index so a chained load picks up the following byte.
  always_comb begin
    case (idx_d)
      3'd0:    byte_data = SYNC_BYTE;
      3'd1:    byte_data = word_q[31:24];
      3'd2:    byte_data = word_q[23:16];
      3'd3:    byte_data = word_q[15:8];
      3'd4:    byte_data = word_q[7:0];
      3'd5:    byte_data = frame_chk(word_q);
      default: byte_data = SYNC_BYTE;
    endcase
  end

  assign byte_load = load_q || chain_load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FR_IDLE;
      idx_q   <= 3'd0;
      word_q  <= 32'd0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .data_i(byte_data),
    .load_i(byte_load),
    .tx_o  (byte_tx),
    .done_o(byte_done),
    .busy_o(byte_busy)
  );

  assign uart_tx_o    = byte_busy ? byte_tx : 1'b1;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// Scoreboard bench for uart_result_tx: a driver pushes expected frames,
// a line decoder pops and compares each received frame.
module tb_uart_result_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 60 * CPB;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic        data_ready_o, uart_tx_o, busy_o, frame_done_o;

  uart_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o),
    .uart_tx_o   (uart_tx_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] bytes;
    int          hs;
  } exp_t;

  exp_t exp_q[$];
  int   rx_starts[$];
  int   n_cmp = 0, n_bad = 0;
  int   done_cnt = 0;
  int   n_pushed = 0;
  bit   rx_active = 1'b0;

  always @(negedge clk) if (frame_done_o === 1'b1) done_cnt++;

  function automatic logic [47:0] model_frame(input logic [31:0] w);
    logic [47:0] r;
    logic [7:0]  c, byt;
    r = 48'hA5;
    c = 8'h00;
    for (int i = 3; i >= 0; i--) begin
      byt = 8'((w >> (8 * i)) & 32'hFF);
      r   = {r[39:0], byt};
      c   = c ^ byt;
    end
    r = {r[39:0], c};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit keep_valid);
    bit   acc;
    exp_t e;
    acc = 1'b0;
    @(posedge clk); #2;
    data_i       = w;
    data_valid_i = 1'b1;
    for (int t = 0; t < 3000 && !acc; t++) begin
      @(negedge clk);
      if (data_ready_o === 1'b1 && rst_i === 1'b0) acc = 1'b1;
    end
    if (!acc) begin
      check("accept_timeout", 64'd0, 64'd1);
      data_valid_i = 1'b0;
      return;
    end
    e.bytes = model_frame(w);
    e.hs    = cyc + 1;
    exp_q.push_back(e);
    n_pushed++;
    @(posedge clk); #2;
    if (!keep_valid) begin
      data_valid_i = 1'b0;
      data_i       = $urandom;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rx_active) ok = 1'b1;
    end
    check("drain_timeout", 64'(ok), 64'd1);
  endtask

  // Line decoder: every bit is sampled on all CPB cycles and must be constant.
  initial begin : rx
    logic [9:0]  bits;
    logic [47:0] got;
    bit          ab, werr, rerr;
    int          st;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_i !== 1'b0 || uart_tx_o !== 1'b0) continue;
      rx_active = 1'b1;
      st   = cyc;
      ab   = 1'b0;
      werr = 1'b0;
      rerr = 1'b0;
      got  = '0;
      bits = '0;
      for (int b = 0; b < 6 && !ab; b++) begin
        for (int j = 0; j < 10 && !ab; j++) begin
          for (int s = 0; s < CPB && !ab; s++) begin
            if (!(b == 0 && j == 0 && s == 0)) @(negedge clk);
            if (rst_i === 1'b1) ab = 1'b1;
            else begin
              if (s == 0) bits[j] = uart_tx_o;
              else if (uart_tx_o !== bits[j]) werr = 1'b1;
              if (data_ready_o !== 1'b0) rerr = 1'b1;
            end
          end
        end
        if (!ab) begin
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1) werr = 1'b1;
          got = {got[39:0], bits[8:1]};
        end
      end
      if (ab) begin
        if (exp_q.size() > 0) exp_q.delete(0);
        rx_active = 1'b0;
        continue;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_frame", {16'd0, got}, 64'd0);
        rx_active = 1'b0;
        continue;
      end
      e = exp_q.pop_front();
      check("frame_bytes", {16'd0, got}, {16'd0, e.bytes});
      check("start_latency", 64'(st), 64'(e.hs + 1));
      check("bit_timing", 64'(werr), 64'd0);
      check("ready_low_in_frame", 64'(rerr), 64'd0);
      rx_starts.push_back(st);
      @(negedge clk);
      check("frame_done_at_end", 64'(frame_done_o), 64'd1);
      check("busy_at_done", 64'(busy_o), 64'd1);
      @(negedge clk);
      check("frame_done_width", 64'(frame_done_o), 64'd0);
      check("busy_after_done", 64'(busy_o), 64'd0);
      check("ready_after_done", 64'(data_ready_o), 64'd1);
      rx_active = 1'b0;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit idle_ok;
    int n0, d0;
    rst_i        = 1'b1;
    data_valid_i = 1'b1;
    data_i       = 32'hDEADBEEF;

    // Valid held during reset must not be taken.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 64'(uart_tx_o), 64'd1);
    check("rst_ready", 64'(data_ready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(frame_done_o), 64'd0);
    @(posedge clk); #2;
    data_valid_i = 1'b0;
    rst_i        = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(data_ready_o), 64'd1);

    idle_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (uart_tx_o !== 1'b1 || busy_o !== 1'b0) idle_ok = 1'b0;
    end
    check("idle_line", 64'(idle_ok), 64'd1);

    send_word(32'h12345678, 1'b0);
    wait_idle();

    send_word(32'hFFFFFFFF, 1'b0);
    data_i = 32'h0;
    wait_idle();

    n0 = rx_starts.size();
    send_word(32'h00000001, 1'b1);
    data_i = 32'h80000000;
    send_word(32'h80000000, 1'b0);
    wait_idle();
    check("holdoff_frames", 64'(rx_starts.size() - n0), 64'd2);
    if (rx_starts.size() >= n0 + 2)
      check("holdoff_spacing", 64'(rx_starts[n0+1] - rx_starts[n0]), 64'(FRAME_CYC + 3));

    // Reset during byte 3 of a frame.
    d0 = done_cnt;
    send_word($urandom, 1'b0);
    repeat (135) @(posedge clk);
    #2 rst_i = 1'b1;
    @(posedge clk); #2;
    rst_i = 1'b0;
    @(negedge clk);
    check("abort_tx_high", 64'(uart_tx_o), 64'd1);
    check("abort_ready", 64'(data_ready_o), 64'd1);
    check("abort_busy", 64'(busy_o), 64'd0);
    idle_ok = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx_o !== 1'b1) idle_ok = 1'b0;
    end
    check("abort_line_idle", 64'(idle_ok), 64'd1);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_queue_flushed", 64'(exp_q.size()), 64'd0);

    send_word(32'hA5A5A5A5, 1'b0);
    wait_idle();

    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      send_word($urandom, 1'b0);
    end
    wait_idle();

    check("done_count", 64'(done_cnt), 64'(n_pushed - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
